// File: rtl/axi4l_mst_cmd.sv
// rtl/axi4l_mst_cmd.sv - single-outstanding AXI4-Lite master driven by a valid/ready command stream
//
// Purpose: accepts one command at a time (write or read), runs the matching
// AXI4-Lite transaction (AW+W then B, or AR then R), and returns one response
// per command on the rsp_* stream.
//
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command stream in
//   rsp_valid/ready/write/rdata/resp         response stream out
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*   AXI4-Lite master
//   stat_wr_cnt/stat_rd_cnt/stat_err_cnt     only when AXI4L_MST_STATS_EN is defined
//
// Optional feature macro: AXI4L_MST_STATS_EN (transaction / error counters).

module axi4l_mst_cmd #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,

`ifdef AXI4L_MST_STATS_EN
    output logic [31:0]               stat_wr_cnt,
    output logic [31:0]               stat_rd_cnt,
    output logic [31:0]               stat_err_cnt,
`endif

    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    generate
        if ((C_DATA_WIDTH != 32) && (C_DATA_WIDTH != 64)) begin : g_bad_dw
            $error("axi4l_mst_cmd: C_DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_WRREQ  = 3'd2;
    localparam logic [2:0] S_WRRESP = 3'd3;
    localparam logic [2:0] S_RDADDR = 3'd4;
    localparam logic [2:0] S_RDDATA = 3'd5;
    localparam logic [2:0] S_RSP    = 3'd6;

    logic [2:0]                state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                      write_q, write_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;

    // A channel counts as done once its valid has already dropped, or it is
    // handshaking this cycle; this lets AW and W complete in either order.
    logic aw_done, w_done;
    logic b_hs, r_hs;

    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;
    assign b_hs    = (state_q == S_WRRESP) && m_axi_bvalid;
    assign r_hs    = (state_q == S_RDDATA) && m_axi_rvalid;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        case (state_q)
            S_RST: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d   = cmd_write ? S_WRREQ : S_RDADDR;
                    addr_d    = cmd_addr;
                    write_d   = cmd_write;
                    wdata_d   = cmd_write ? cmd_wdata : '0;
                    wstrb_d   = cmd_write ? cmd_wstrb : '0;
                    awvalid_d = cmd_write;
                    wvalid_d  = cmd_write;
                end
            end
            S_WRREQ: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done)          state_d   = S_WRRESP;
            end
            S_WRRESP: begin
                if (m_axi_bvalid) begin
                    state_d = S_RSP;
                    resp_d  = m_axi_bresp;
                    rdata_d = '0;
                end
            end
            S_RDADDR: begin
                if (m_axi_arready) state_d = S_RDDATA;
            end
            S_RDDATA: begin
                if (m_axi_rvalid) begin
                    state_d = S_RSP;
                    resp_d  = m_axi_rresp;
                    rdata_d = m_axi_rdata;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                // Unreachable encodings recover through the reset state.
                state_d   = S_RST;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase
    end

`ifdef AXI4L_MST_STATS_EN
    logic [31:0] stat_wr_cnt_q, stat_wr_cnt_d;
    logic [31:0] stat_rd_cnt_q, stat_rd_cnt_d;
    logic [31:0] stat_err_cnt_q, stat_err_cnt_d;

    always_comb begin
        stat_wr_cnt_d  = stat_wr_cnt_q;
        stat_rd_cnt_d  = stat_rd_cnt_q;
        stat_err_cnt_d = stat_err_cnt_q;
        if (b_hs) stat_wr_cnt_d = stat_wr_cnt_q + 32'd1;
        if (r_hs) stat_rd_cnt_d = stat_rd_cnt_q + 32'd1;
        // B and R handshakes are mutually exclusive, so one increment suffices.
        if ((b_hs && (m_axi_bresp != 2'b00)) || (r_hs && (m_axi_rresp != 2'b00)))
            stat_err_cnt_d = stat_err_cnt_q + 32'd1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_wr_cnt_q  <= '0;
            stat_rd_cnt_q  <= '0;
            stat_err_cnt_q <= '0;
        end else begin
            stat_wr_cnt_q  <= stat_wr_cnt_d;
            stat_rd_cnt_q  <= stat_rd_cnt_d;
            stat_err_cnt_q <= stat_err_cnt_d;
        end
    end

    assign stat_wr_cnt  = stat_wr_cnt_q;
    assign stat_rd_cnt  = stat_rd_cnt_q;
    assign stat_err_cnt = stat_err_cnt_q;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_RST;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == S_WRRESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == S_RDADDR);
    assign m_axi_rready  = (state_q == S_RDDATA);

endmodule
